// File: rtl/ram_2port_rd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_2port_rd_ctrl_pkg                                                      |
// | Shared RAM geometry, read latency and FSM state encoding (reader + writer) |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ram_2port_rd_ctrl_pkg;

    localparam int C_ADDR_W     = 5;
    localparam int C_DATA_W     = 8;
    localparam int C_DEPTH      = 32;
    localparam int C_RAM_RD_LAT = 2;
    localparam int C_ERR_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/ram_2port_rd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_2port_rd_ctrl_if                                                       |
// | Writer handshake, RAM read port and checked output stream of the reader    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface ram_2port_rd_ctrl_if
    import ram_2port_rd_ctrl_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W,
    parameter int ERR_W  = C_ERR_W
);

    logic              wr_done;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              rd_busy;
    logic [DATA_W-1:0] dout;
    logic              dout_vld;
    logic              rd_done;
    logic              err_flag;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        input  wr_done, ram_rd_data,
        output ram_rd_en, ram_rd_addr, rd_busy, dout, dout_vld, rd_done, err_flag, err_cnt
    );

    modport slave (
        output wr_done, ram_rd_data,
        input  ram_rd_en, ram_rd_addr, rd_busy, dout, dout_vld, rd_done, err_flag, err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/ram_2port_rd_ctrl_rd_lat_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_2port_rd_ctrl_rd_lat_pipe                                              |
// | Valid/address shift register that tracks reads through the RAM latency    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ram_2port_rd_ctrl_rd_lat_pipe #(
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_vld,
    output logic             pre_vld,
    output logic [TAG_W-1:0] pre_tag
);

    logic [STAGES-1:0]             r_vld;
    // The tag is consumed one stage before the end, so the final tag stage is never stored.
    logic [STAGES-2:0][TAG_W-1:0]  r_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[STAGES-2:0], in_vld};
        end
    end

    if (STAGES == 2) begin : g_tag_one
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_tag <= '0;
            end else begin
                r_tag[0] <= in_tag;
            end
        end
    end else begin : g_tag_shift
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_tag <= '0;
            end else begin
                r_tag <= {r_tag[STAGES-3:0], in_tag};
            end
        end
    end

    assign out_vld = r_vld[STAGES-1];
    assign pre_vld = r_vld[STAGES-2];
    assign pre_tag = r_tag[STAGES-2];

endmodule
`default_nettype wire

// File: rtl/ram_2port_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_2port_rd_ctrl                                                          |
// | Reads a written RAM block, streams it out and checks data == address      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ram_2port_rd_ctrl
    import ram_2port_rd_ctrl_pkg::*;
#(
    parameter int ADDR_W = C_ADDR_W,
    parameter int DATA_W = C_DATA_W,
    parameter int DEPTH  = C_DEPTH,
    parameter int RD_LAT = C_RAM_RD_LAT,
    parameter int ERR_W  = C_ERR_W
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    ram_2port_rd_ctrl_if.master bus
);

    localparam int                STAGES      = RD_LAT + 1;
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    rd_state_t         r_state;
    logic              r_pending;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_busy;
    logic              r_rd_done;
    logic [DATA_W-1:0] r_dout;
    logic              r_err_flag;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_out_vld;
    logic              w_pre_vld;
    logic [ADDR_W-1:0] w_pre_tag;
    logic [DATA_W-1:0] w_expected;
    logic              w_mismatch;

    ram_2port_rd_ctrl_rd_lat_pipe #(
        .STAGES (STAGES),
        .TAG_W  (ADDR_W)
    ) u_lat_pipe (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .in_vld  (r_rd_en),
        .in_tag  (r_rd_addr),
        .out_vld (w_out_vld),
        .pre_vld (w_pre_vld),
        .pre_tag (w_pre_tag)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_busy    <= 1'b0;
            r_rd_done <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            if (bus.wr_done && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.wr_done || r_pending) begin
                        r_state   <= ST_READ;
                        r_pending <= 1'b0;
                        r_rd_en   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (r_rd_addr == C_LAST_ADDR) begin
                        r_state   <= ST_DRAIN;
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= '0;
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Words leave contiguously, so an empty pre-stage behind a valid output marks the last one.
                    if (w_out_vld && !w_pre_vld) begin
                        r_state   <= ST_DONE;
                        r_rd_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM q is valid while the word sits one stage short of the output, i.e. the edge that loads dout.
    assign w_expected = DATA_W'(w_pre_tag);
    assign w_mismatch = w_pre_vld && (bus.ram_rd_data != w_expected);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_dout     <= '0;
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_pre_vld) begin
                r_dout <= bus.ram_rd_data;
            end
            if (w_mismatch) begin
                r_err_flag <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_W'(1);
                end
            end
        end
    end

    assign bus.ram_rd_en   = r_rd_en;
    assign bus.ram_rd_addr = r_rd_addr;
    assign bus.rd_busy     = r_busy;
    assign bus.dout        = r_dout;
    assign bus.dout_vld    = w_out_vld;
    assign bus.rd_done     = r_rd_done;
    assign bus.err_flag    = r_err_flag;
    assign bus.err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ram_2port_rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ram_2port_rd_ctrl                                                       |
// | Directed bench: RAM model, scoreboard of read words, timing and error checks|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ram_2port_rd_ctrl;

    localparam int DEPTH = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc   = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem [0:DEPTH-1];
    logic [4:0] r_ra;
    logic [7:0] sb [$];

    int en_cnt, en_first, en_last;
    int vld_cnt, vld_first, vld_last;
    int done_cnt, done_cyc;
    int busy_cnt, busy_first, busy_last;

    ram_2port_rd_ctrl_if #(.ADDR_W(5), .DATA_W(8), .ERR_W(16)) bus  ();
    ram_2port_rd_ctrl_if #(.ADDR_W(5), .DATA_W(8), .ERR_W(4))  bus2 ();

    ram_2port_rd_ctrl #(
        .ADDR_W(5), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(2), .ERR_W(16)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    ram_2port_rd_ctrl #(
        .ADDR_W(5), .DATA_W(8), .DEPTH(DEPTH), .RD_LAT(2), .ERR_W(4)
    ) dut_sat (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus2)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle RAM: registered address, registered q
    always @(posedge clk) begin
        r_ra            <= bus.ram_rd_addr;
        bus.ram_rd_data <= mem[r_ra];
    end

    assign bus2.ram_rd_data = 8'hFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        en_cnt = 0;   en_first = -1;  en_last = -1;
        vld_cnt = 0;  vld_first = -1; vld_last = -1;
        done_cnt = 0; done_cyc = -1;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
    endtask

    // Advance to the next falling edge and observe the main DUT there.
    task automatic tick();
        @(negedge clk);
        if (bus.ram_rd_en) begin
            if (en_cnt == 0) en_first = cyc;
            en_last = cyc;
            check("rd_addr", 32'(bus.ram_rd_addr), en_cnt % DEPTH);
            en_cnt++;
        end else begin
            check("rd_addr_idle", 32'(bus.ram_rd_addr), 0);
        end
        if (bus.dout_vld) begin
            if (vld_cnt == 0) vld_first = cyc;
            vld_last = cyc;
            vld_cnt++;
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else                check("dout", 32'(bus.dout), 32'(sb.pop_front()));
        end
        if (bus.rd_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.rd_busy) begin
            if (busy_cnt == 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
        end
    endtask

    task automatic step_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse(input int n, input bit sel);
        step_to(n);
        if (!sel) begin
            bus.wr_done = 1'b1;
            for (int i = 0; i < DEPTH; i++) sb.push_back(mem[i]);
        end else begin
            bus2.wr_done = 1'b1;
        end
        tick();
        bus.wr_done  = 1'b0;
        bus2.wr_done = 1'b0;
    endtask

    task automatic check_block(input int k);
        check("en_first",   en_first,   k + 1);
        check("en_last",    en_last,    k + DEPTH);
        check("en_cnt",     en_cnt,     DEPTH);
        check("vld_first",  vld_first,  k + 4);
        check("vld_last",   vld_last,   k + DEPTH + 3);
        check("vld_cnt",    vld_cnt,    DEPTH);
        check("done_cyc",   done_cyc,   k + DEPTH + 4);
        check("done_cnt",   done_cnt,   1);
        check("busy_first", busy_first, k + 1);
        check("busy_last",  busy_last,  k + DEPTH + 4);
        check("busy_cnt",   busy_cnt,   DEPTH + 4);
        check("sb_empty",   sb.size(),  0);
    endtask

    initial begin
        bus.wr_done  = 1'b0;
        bus2.wr_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        clear_stats();

        // Reset state
        step_to(3);
        check("rst_rd_en",    32'(bus.ram_rd_en),  0);
        check("rst_dout",     32'(bus.dout),       0);
        check("rst_dout_vld", 32'(bus.dout_vld),   0);
        check("rst_rd_done",  32'(bus.rd_done),    0);
        check("rst_busy",     32'(bus.rd_busy),    0);
        check("rst_err_flag", 32'(bus.err_flag),   0);
        check("rst_err_cnt",  32'(bus.err_cnt),    0);
        check("rst_err_cnt2", 32'(bus2.err_cnt),   0);
        rst_n = 1'b1;

        // Nominal block
        clear_stats();
        pulse(10, 1'b0);
        step_to(50);
        check_block(10);
        check("dout_hold", 32'(bus.dout),     31);
        check("t1_errcnt", 32'(bus.err_cnt),  0);
        check("t1_errflg", 32'(bus.err_flag), 0);

        // Corrupted words, then a clean block
        mem[5]  = 8'hA5;
        mem[20] = 8'h00;
        clear_stats();
        pulse(60, 1'b0);
        step_to(68);
        check("t2_flag_before", 32'(bus.err_flag), 0);
        step_to(69);
        check("t2_flag_at", 32'(bus.err_flag), 1);
        step_to(100);
        check_block(60);
        check("t2_errcnt", 32'(bus.err_cnt),  2);
        check("t2_errflg", 32'(bus.err_flag), 1);
        mem[5]  = 8'd5;
        mem[20] = 8'd20;
        clear_stats();
        pulse(110, 1'b0);
        step_to(150);
        check_block(110);
        check("t2_clean_errcnt", 32'(bus.err_cnt),  2);
        check("t2_clean_errflg", 32'(bus.err_flag), 1);

        // Back-to-back: second wr_done during READ
        clear_stats();
        pulse(160, 1'b0);
        pulse(180, 1'b0);
        step_to(196);
        check("t3_rd_done", 32'(bus.rd_done), 1);
        step_to(197);
        check("t3_idle_busy", 32'(bus.rd_busy),   0);
        check("t3_idle_en",   32'(bus.ram_rd_en), 0);
        step_to(198);
        check("t3_restart_en",   32'(bus.ram_rd_en), 1);
        check("t3_restart_busy", 32'(bus.rd_busy),   1);
        step_to(245);
        check("t3_en_first", en_first, 161);
        check("t3_en_last",  en_last,  229);
        check("t3_en_cnt",   en_cnt,   64);
        check("t3_vld_cnt",  vld_cnt,  64);
        check("t3_done_cnt", done_cnt, 2);
        check("t3_done_cyc", done_cyc, 233);
        check("t3_sb_empty", sb.size(), 0);

        // Reset in the middle of a block
        clear_stats();
        pulse(260, 1'b0);
        step_to(275);
        check("t4_errcnt_pre", 32'(bus.err_cnt), 2);
        rst_n = 1'b0;
        step_to(276);
        check("t4_rd_en",    32'(bus.ram_rd_en),   0);
        check("t4_addr",     32'(bus.ram_rd_addr), 0);
        check("t4_dout",     32'(bus.dout),        0);
        check("t4_dout_vld", 32'(bus.dout_vld),    0);
        check("t4_rd_done",  32'(bus.rd_done),     0);
        check("t4_busy",     32'(bus.rd_busy),     0);
        check("t4_err_flag", 32'(bus.err_flag),    0);
        check("t4_err_cnt",  32'(bus.err_cnt),     0);
        sb.delete();
        clear_stats();
        step_to(277);
        rst_n = 1'b1;
        step_to(340);
        check("t4_no_en",   en_cnt,   0);
        check("t4_no_vld",  vld_cnt,  0);
        check("t4_no_done", done_cnt, 0);
        check("t4_no_busy", busy_cnt, 0);

        // Saturating error counter (ERR_W=4, RAM returns all-ones)
        pulse(360, 1'b1);
        step_to(363);
        check("t5_cnt_0",  32'(bus2.err_cnt), 0);
        step_to(364);
        check("t5_cnt_1",  32'(bus2.err_cnt), 1);
        step_to(377);
        check("t5_cnt_14", 32'(bus2.err_cnt), 14);
        step_to(378);
        check("t5_cnt_15", 32'(bus2.err_cnt), 15);
        pulse(410, 1'b1);
        step_to(460);
        check("t5_cnt_hold", 32'(bus2.err_cnt),  15);
        check("t5_flag",     32'(bus2.err_flag), 1);
        check("t5_busy",     32'(bus2.rd_busy),  0);

        // Long idle with no wr_done
        clear_stats();
        step_to(1460);
        check("t6_no_en",   en_cnt,   0);
        check("t6_no_vld",  vld_cnt,  0);
        check("t6_no_done", done_cnt, 0);
        check("t6_no_busy", busy_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
